mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Drives a multi-cycle data-memory bus with a req/ack handshake for loads and stores.
- Stalls the pipeline while an access is outstanding, then registers results into the MEM/WB stage.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM stage: drives the req/ack data bus for loads/stores, stalls the
// pipeline while an access is outstanding and registers the MEM/WB bundle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   *M                        EX/MEM pipeline register outputs
//   stallM                    combinational freeze of PC..EX/MEM
//   mem_req/we/addr/wdata     registered bus request side
//   mem_ack/rdata             bus completion and load data
//   *W                        registered MEM/WB outputs
//   align_err, bus_err        one-cycle error pulses
module mem_access_unit #(
  parameter logic [1:0] LOAD_SRC       = 2'b01,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Regfile_weM,
  input  logic        DataMem_weM,
  input  logic [4:0]  writeRegAddrM,
  input  logic [1:0]  regSrc_muxM,
  input  logic [31:0] aluOutM,
  input  logic [31:0] writeDataM,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        Regfile_weW,
  output logic [4:0]  writeRegAddrW,
  output logic [1:0]  regSrc_muxW,
  output logic [31:0] aluOutW,
  output logic [31:0] readDataW,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic [31:0]   capData;
  logic          toFlag;

  logic isLoad;
  logic isStore;
  logic isAccess;
  logic aligned;

  assign isLoad   = (regSrc_muxM == LOAD_SRC);
  assign isStore  = DataMem_weM;
  assign isAccess = isLoad | isStore;
  assign aligned  = (aluOutM[1:0] == 2'b00);

  // Hold EX/MEM from the detect cycle through the last WAIT cycle.
  assign stallM = (state == WAIT) |
                  ((state == IDLE) & isAccess & aligned);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      waitCnt       <= '0;
      capData       <= '0;
      toFlag        <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      Regfile_weW   <= 1'b0;
      writeRegAddrW <= '0;
      regSrc_muxW   <= '0;
      aluOutW       <= '0;
      readDataW     <= '0;
      align_err     <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (isAccess && aligned) begin
            mem_req     <= 1'b1;
            mem_we      <= isStore;
            mem_addr    <= {aluOutM[31:2], 2'b00};
            mem_wdata   <= writeDataM;
            waitCnt     <= '0;
            Regfile_weW <= 1'b0;
            state       <= WAIT;
          end else begin
            // Misaligned accesses retire without a bus cycle and
            // without a register write.
            Regfile_weW   <= Regfile_weM & ~isAccess;
            writeRegAddrW <= writeRegAddrM;
            regSrc_muxW   <= regSrc_muxM;
            aluOutW       <= aluOutM;
            readDataW     <= '0;
            align_err     <= isAccess;
          end
        end
        WAIT: begin
          Regfile_weW <= 1'b0;
          if (mem_ack) begin
            mem_req <= 1'b0;
            capData <= mem_rdata;
            state   <= DONE;
          end else if (waitCnt == CNT_LAST) begin
            mem_req <= 1'b0;
            capData <= '0;
            toFlag  <= 1'b1;
            state   <= DONE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DONE: begin
          Regfile_weW   <= Regfile_weM & ~toFlag;
          writeRegAddrW <= writeRegAddrM;
          regSrc_muxW   <= regSrc_muxM;
          aluOutW       <= aluOutM;
          readDataW     <= isStore ? 32'h0 : capData;
          bus_err       <= toFlag;
          toFlag        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-cycle vector table plus
// hand-written load, store, timeout and reset-in-WAIT sequences.
module tb_mem_access_unit;

  localparam logic [1:0] LD = 2'b01;

  logic        clk;
  logic        rst;
  logic        Regfile_weM;
  logic        DataMem_weM;
  logic [4:0]  writeRegAddrM;
  logic [1:0]  regSrc_muxM;
  logic [31:0] aluOutM;
  logic [31:0] writeDataM;
  logic        stallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        Regfile_weW;
  logic [4:0]  writeRegAddrW;
  logic [1:0]  regSrc_muxW;
  logic [31:0] aluOutW;
  logic [31:0] readDataW;
  logic        align_err;
  logic        bus_err;

  int passed = 0;
  int total  = 0;

  mem_access_unit #(
    .LOAD_SRC(LD),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Regfile_weM(Regfile_weM),
    .DataMem_weM(DataMem_weM),
    .writeRegAddrM(writeRegAddrM),
    .regSrc_muxM(regSrc_muxM),
    .aluOutM(aluOutM),
    .writeDataM(writeDataM),
    .stallM(stallM),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .Regfile_weW(Regfile_weW),
    .writeRegAddrW(writeRegAddrW),
    .regSrc_muxW(regSrc_muxW),
    .aluOutW(aluOutW),
    .readDataW(readDataW),
    .align_err(align_err),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        mwe;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        eStall;
    logic        eWeW;
    logic        eAlign;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic setM(logic we, logic mwe, logic [4:0] rd,
                      logic [1:0] src, logic [31:0] alu,
                      logic [31:0] wd);
    Regfile_weM   = we;
    DataMem_weM   = mwe;
    writeRegAddrM = rd;
    regSrc_muxM   = src;
    aluOutM       = alu;
    writeDataM    = wd;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    setM(0, 0, 0, 0, 0, 0);

    vecs[0] = '{1, 0, 5'd3,  2'b00, 32'h5,        32'h0, 0, 1, 0};
    vecs[1] = '{1, 0, 5'd7,  2'b10, 32'hDEADBEEF, 32'h0, 0, 1, 0};
    vecs[2] = '{1, 0, 5'd4,  LD,    32'h102,      32'h0, 0, 0, 1};
    vecs[3] = '{0, 1, 5'd0,  2'b00, 32'h203,      32'h9, 0, 0, 1};
    vecs[4] = '{0, 0, 5'd9,  2'b11, 32'h1,        32'h0, 0, 0, 0};
    vecs[5] = '{1, 0, 5'd31, 2'b00, 32'hFFFFFFFF, 32'h0, 0, 1, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stallM, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_weW", Regfile_weW, 0);
    chk("rst_aluW", aluOutW, 0);
    chk("rst_rdW", readDataW, 0);
    chk("rst_errs", {align_err, bus_err}, 0);
    rst = 1'b0;

    // Single-cycle table: inputs applied, outputs checked next cycle.
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk($sformatf("v%0d_weW", i-1), Regfile_weW, vecs[i-1].eWeW);
        chk($sformatf("v%0d_rdW", i-1), writeRegAddrW, vecs[i-1].rd);
        chk($sformatf("v%0d_srcW", i-1), regSrc_muxW, vecs[i-1].src);
        chk($sformatf("v%0d_aluW", i-1), aluOutW, vecs[i-1].alu);
        chk($sformatf("v%0d_rdata", i-1), readDataW, 0);
        chk($sformatf("v%0d_align", i-1), align_err, vecs[i-1].eAlign);
        chk($sformatf("v%0d_req", i-1), mem_req, 0);
      end
      if (i < 6) begin
        setM(vecs[i].we, vecs[i].mwe, vecs[i].rd, vecs[i].src,
             vecs[i].alu, vecs[i].wd);
        #1;
        chk($sformatf("v%0d_stall", i), stallM, vecs[i].eStall);
      end
    end

    // Load at 0x100, ack on first WAIT cycle.
    setM(1, 0, 5'd5, LD, 32'h100, 32'h0);
    #1 chk("ld_stall0", stallM, 1);
    @(negedge clk);
    chk("ld_req", mem_req, 1);
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_we", mem_we, 0);
    chk("ld_stall1", stallM, 1);
    chk("ld_bubble", Regfile_weW, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    chk("ld_done_req", mem_req, 0);
    chk("ld_done_stall", stallM, 0);
    @(negedge clk);
    chk("ld_rdW", readDataW, 32'hCAFEF00D);
    chk("ld_weW", Regfile_weW, 1);
    chk("ld_rdaddrW", writeRegAddrW, 5);
    setM(0, 0, 0, 0, 32'h8, 0);
    @(negedge clk);
    chk("nop_rdW", readDataW, 0);

    // Store at 0x204, ack on the third WAIT cycle.
    setM(0, 1, 5'd0, 2'b00, 32'h204, 32'h12345678);
    #1 chk("st_stall0", stallM, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("st_req%0d", c), mem_req, 1);
      chk($sformatf("st_we%0d", c), mem_we, 1);
      chk($sformatf("st_wd%0d", c), mem_wdata, 32'h12345678);
      chk($sformatf("st_addr%0d", c), mem_addr, 32'h204);
      chk($sformatf("st_stall%0d", c), stallM, 1);
      if (c == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF0000;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("st_done_stall", stallM, 0);
    chk("st_done_req", mem_req, 0);
    @(negedge clk);
    chk("st_weW", Regfile_weW, 0);
    chk("st_rdW", readDataW, 0);

    // Load at 0x300 with no ack: 16 WAIT cycles then bus_err.
    setM(1, 0, 5'd6, LD, 32'h300, 32'h0);
    #1 chk("to_stall0", stallM, 1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("to_req%0d", c), mem_req, 1);
      chk($sformatf("to_stall%0d", c), stallM, 1);
    end
    @(negedge clk);
    chk("to_req_fall", mem_req, 0);
    chk("to_done_stall", stallM, 0);
    chk("to_berr_early", bus_err, 0);
    @(negedge clk);
    chk("to_berr", bus_err, 1);
    chk("to_rdW", readDataW, 0);
    chk("to_weW", Regfile_weW, 0);
    setM(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("to_berr_once", bus_err, 0);

    // Reset on the second WAIT cycle of a load.
    setM(1, 0, 5'd2, LD, 32'h400, 32'h0);
    @(negedge clk);
    chk("rw_req1", mem_req, 1);
    @(negedge clk);
    chk("rw_req2", mem_req, 1);
    rst = 1'b1;
    setM(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rw_req", mem_req, 0);
    chk("rw_stall", stallM, 0);
    chk("rw_W", {Regfile_weW, writeRegAddrW, regSrc_muxW}, 0);
    chk("rw_aluW", aluOutW, 0);
    chk("rw_rdW", readDataW, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rw_ack_req", mem_req, 0);
    chk("rw_ack_rdW", readDataW, 0);
    chk("rw_ack_errs", {align_err, bus_err}, 0);
    @(negedge clk);
    chk("rw_ack_rdW2", readDataW, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
